// File: rtl/uart_tx_fifo_drain.sv
// UART transmit serializer draining an 8-bit byte FIFO: pops one byte per frame
// and shifts it out as 8N1 (or 8E1 when PARITY_EN=1), all outputs registered.
module uart_tx_fifo_drain #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter bit          PARITY_EN    = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       txEn,
  input  logic [7:0] fifoData,
  input  logic       fifoEmpty,
  output logic       fifoRe,
  output logic       tx,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

  state_t      r_state;
  logic [15:0] r_baud;
  logic [2:0]  r_bit;
  logic [7:0]  r_shift;
  logic        r_par;
  logic        r_fifo_re;
  logic        r_tx;
  logic        r_busy;

  state_t      w_state;
  logic [15:0] w_baud;
  logic [2:0]  w_bit;
  logic [7:0]  w_shift;
  logic        w_par;
  logic        w_fifo_re;
  logic        w_tx;
  logic        w_busy;
  logic        w_bit_end;

  assign w_bit_end = (r_baud == BAUD_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_baud    <= '0;
      r_bit     <= '0;
      r_shift   <= '0;
      r_par     <= 1'b0;
      r_fifo_re <= 1'b0;
      r_tx      <= 1'b1;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_baud    <= w_baud;
      r_bit     <= w_bit;
      r_shift   <= w_shift;
      r_par     <= w_par;
      r_fifo_re <= w_fifo_re;
      r_tx      <= w_tx;
      r_busy    <= w_busy;
    end
  end

  // tx is registered, so each bit boundary loads the value of the bit that follows it.
  always_comb begin
    w_state   = r_state;
    w_baud    = r_baud + 16'd1;
    w_bit     = r_bit;
    w_shift   = r_shift;
    w_par     = r_par;
    w_fifo_re = 1'b0;
    w_tx      = r_tx;
    w_busy    = r_busy;

    case (r_state)
      IDLE: begin
        w_baud = '0;
        w_tx   = 1'b1;
        w_busy = 1'b0;
        if (txEn && !fifoEmpty) begin
          w_state   = START;
          w_shift   = fifoData;
          w_par     = ^fifoData;
          w_fifo_re = 1'b1;
          w_tx      = 1'b0;
          w_busy    = 1'b1;
          w_bit     = '0;
        end
      end

      START: begin
        if (w_bit_end) begin
          w_baud  = '0;
          w_state = DATA;
          w_tx    = r_shift[0];
        end
      end

      DATA: begin
        if (w_bit_end) begin
          w_baud  = '0;
          w_shift = {1'b0, r_shift[7:1]};
          if (r_bit == 3'd7) begin
            w_bit = '0;
            if (PARITY_EN) begin
              w_state = PARITY;
              w_tx    = r_par;
            end else begin
              w_state = STOP;
              w_tx    = 1'b1;
            end
          end else begin
            w_bit = r_bit + 3'd1;
            w_tx  = r_shift[1];
          end
        end
      end

      PARITY: begin
        if (w_bit_end) begin
          w_baud  = '0;
          w_state = STOP;
          w_tx    = 1'b1;
        end
      end

      STOP: begin
        if (w_bit_end) begin
          w_baud  = '0;
          w_state = IDLE;
          w_tx    = 1'b1;
          w_busy  = 1'b0;
        end
      end

      default: begin
        w_state = IDLE;
        w_baud  = '0;
        w_tx    = 1'b1;
        w_busy  = 1'b0;
      end
    endcase
  end

  assign fifoRe = r_fifo_re;
  assign tx     = r_tx;
  assign busy   = r_busy;

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// Bench for uart_tx_fifo_drain: two instances (8N1 and 8E1, 4 clocks per bit) driven
// from queue-backed FIFOs and checked every cycle against a frame-timing model.
module tb_uart_tx_fifo_drain;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       txEn [2];
  logic [7:0] fdat [2];
  logic       fempty [2];
  logic       fifoRe_o [2];
  logic       tx_o [2];
  logic       busy_o [2];

  logic [7:0] q0 [$];
  logic [7:0] q1 [$];

  int nchecks = 0;
  int nerr    = 0;

  longint     cyc = 0;
  bit         m_act [2];
  longint     m_start [2];
  longint     m_free [2];
  logic [10:0] m_frame [2];

  int         re_cnt [2];
  longint     re_prev [2];
  longint     re_last [2];
  int         busy_cnt [2];

  uart_tx_fifo_drain #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b0)) u_dut0 (
    .clk(clk), .reset(reset), .txEn(txEn[0]), .fifoData(fdat[0]),
    .fifoEmpty(fempty[0]), .fifoRe(fifoRe_o[0]), .tx(tx_o[0]), .busy(busy_o[0])
  );

  uart_tx_fifo_drain #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b1)) u_dut1 (
    .clk(clk), .reset(reset), .txEn(txEn[1]), .fifoData(fdat[1]),
    .fifoEmpty(fempty[1]), .fifoRe(fifoRe_o[1]), .tx(tx_o[1]), .busy(busy_o[1])
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // FIFO environment: pops the head whenever a pop strobe is seen.
  initial begin
    for (int k = 0; k < 2; k++) begin
      fempty[k] = 1'b1;
      fdat[k]   = 8'h00;
    end
    forever begin
      @(negedge clk);
      if (fifoRe_o[0] === 1'b1 && q0.size() > 0) void'(q0.pop_front());
      if (fifoRe_o[1] === 1'b1 && q1.size() > 0) void'(q1.pop_front());
      fempty[0] = (q0.size() == 0);
      fdat[0]   = (q0.size() != 0) ? q0[0] : 8'h00;
      fempty[1] = (q1.size() == 0);
      fdat[1]   = (q1.size() != 0) ? q1[0] : 8'h00;
    end
  end

  // Frame model: a frame starting at edge c drives frame bit (t-c)/CPB after edge t,
  // lasts nbits*CPB cycles, and a new start needs at least one idle edge afterwards.
  initial begin
    for (int k = 0; k < 2; k++) begin
      m_act[k]   = 1'b0;
      m_start[k] = 0;
      m_free[k]  = 0;
      m_frame[k] = '1;
    end
    forever begin
      @(posedge clk);
      cyc++;
      for (int k = 0; k < 2; k++) begin
        int nb;
        nb = (k == 1) ? 11 : 10;
        if (reset !== 1'b1) begin
          m_act[k]  = 1'b0;
          m_free[k] = 0;
        end else begin
          if (m_act[k] && cyc == m_start[k] + longint'(nb * CPB)) begin
            m_act[k]  = 1'b0;
            m_free[k] = cyc + 1;
          end
          if (!m_act[k] && cyc >= m_free[k] && txEn[k] === 1'b1 && fempty[k] === 1'b0) begin
            logic [10:0] f;
            f    = '1;
            f[0] = 1'b0;
            for (int i = 0; i < 8; i++) f[i+1] = fdat[k][i];
            if (k == 1) f[9] = ^fdat[k];
            m_act[k]   = 1'b1;
            m_start[k] = cyc;
            m_frame[k] = f;
          end
        end
      end
    end
  end

  // Per-cycle compare plus pulse/busy statistics.
  initial begin
    for (int k = 0; k < 2; k++) begin
      re_cnt[k]   = 0;
      re_prev[k]  = 0;
      re_last[k]  = 0;
      busy_cnt[k] = 0;
    end
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        logic e_tx, e_busy, e_re;
        longint j;
        if (reset !== 1'b1 || !m_act[k]) begin
          e_tx = 1'b1; e_busy = 1'b0; e_re = 1'b0;
        end else begin
          j      = cyc - m_start[k];
          e_tx   = m_frame[k][int'(j / CPB)];
          e_busy = 1'b1;
          e_re   = (j == 0);
        end
        chk($sformatf("tx%0d", k),     32'(tx_o[k]),     32'(e_tx));
        chk($sformatf("busy%0d", k),   32'(busy_o[k]),   32'(e_busy));
        chk($sformatf("fifoRe%0d", k), 32'(fifoRe_o[k]), 32'(e_re));
        if (fifoRe_o[k] === 1'b1) begin
          re_cnt[k]++;
          re_prev[k] = re_last[k];
          re_last[k] = cyc;
        end
        if (busy_o[k] === 1'b1) busy_cnt[k]++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic wait_re(input int k, input int limit);
    int n;
    n = 0;
    @(negedge clk);
    while (fifoRe_o[k] !== 1'b1 && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (fifoRe_o[k] !== 1'b1) begin
      nchecks++; nerr++;
      $display("FAIL wait_re%0d: got no pop expected pop within %0d cycles", k, limit);
    end
  endtask

  task automatic wait_idle(input int k, input int limit);
    int n;
    n = 0;
    while (busy_o[k] !== 1'b0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (busy_o[k] !== 1'b0) begin
      nchecks++; nerr++;
      $display("FAIL wait_idle%0d: got busy expected idle within %0d cycles", k, limit);
    end
  endtask

  // Line receiver: finds the start bit, then samples each bit at its middle.
  task automatic rx_frame(input int k, input int nbits, output logic [10:0] bits);
    int n;
    bits = '1;
    n = 0;
    @(negedge clk);
    while (tx_o[k] !== 1'b0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (tx_o[k] !== 1'b0) begin
      nchecks++; nerr++;
      bits = 'x;
      $display("FAIL rx%0d: got no start bit expected one within 400 cycles", k);
    end else begin
      repeat (CPB / 2) @(negedge clk);
      bits[0] = tx_o[k];
      for (int b = 1; b < nbits; b++) begin
        repeat (CPB) @(negedge clk);
        bits[b] = tx_o[k];
      end
    end
  endtask

  initial begin
    logic [10:0] b1, b2;
    int s_busy, s_re;

    reset   = 1'b1;
    txEn[0] = 1'b1;
    txEn[1] = 1'b1;
    #2 reset = 1'b0;

    // Reset held with a non-empty FIFO and txEn high: nothing may happen.
    q0.push_back(8'h5A);
    q1.push_back(8'h5A);
    repeat (6) @(negedge clk);
    chk("reset_no_pop0", 32'(re_cnt[0]), 32'd0);
    chk("reset_no_pop1", 32'(re_cnt[1]), 32'd0);
    chk("reset_tx0", 32'(tx_o[0]), 32'd1);
    chk("reset_busy1", 32'(busy_o[1]), 32'd0);
    txEn[0] = 1'b0;
    txEn[1] = 1'b0;
    q0.delete();
    q1.delete();
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);

    // Single 0x55 frame, no parity.
    s_busy = busy_cnt[0];
    s_re   = re_cnt[0];
    q0.push_back(8'h55);
    txEn[0] = 1'b1;
    rx_frame(0, 10, b1);
    chk("frame_55", 32'(b1[9:0]), 32'h2AA);
    wait_idle(0, 100);
    repeat (3) @(negedge clk);
    chk("busy_len_55", 32'(busy_cnt[0] - s_busy), 32'd40);
    chk("pops_55", 32'(re_cnt[0] - s_re), 32'd1);
    txEn[0] = 1'b0;

    // Parity frame 0x07 on the 8E1 instance.
    s_busy = busy_cnt[1];
    q1.push_back(8'h07);
    txEn[1] = 1'b1;
    rx_frame(1, 11, b1);
    chk("frame_07_par", 32'(b1), 32'h60E);
    wait_idle(1, 100);
    repeat (3) @(negedge clk);
    chk("busy_len_07", 32'(busy_cnt[1] - s_busy), 32'd44);
    txEn[1] = 1'b0;

    // Back-to-back 0xA3 then 0x0F.
    q0.push_back(8'hA3);
    q0.push_back(8'h0F);
    txEn[0] = 1'b1;
    rx_frame(0, 10, b1);
    rx_frame(0, 10, b2);
    chk("b2b_byte1", 32'(b1[8:1]), 32'hA3);
    chk("b2b_stop1", 32'(b1[9]), 32'd1);
    chk("b2b_byte2", 32'(b2[8:1]), 32'h0F);
    chk("b2b_pop_gap", 32'(re_last[0] - re_prev[0]), 32'd41);
    wait_idle(0, 100);
    txEn[0] = 1'b0;
    repeat (3) @(negedge clk);

    // txEn dropped during D3 of 0x81; the queued 0x3C must wait for txEn.
    q0.push_back(8'h81);
    q0.push_back(8'h3C);
    txEn[0] = 1'b1;
    wait_re(0, 20);
    repeat (17) @(negedge clk);
    txEn[0] = 1'b0;
    s_re = re_cnt[0];
    wait_idle(0, 100);
    repeat (20) @(negedge clk);
    chk("txen_low_no_pop", 32'(re_cnt[0] - s_re), 32'd0);
    txEn[0] = 1'b1;
    @(negedge clk);
    chk("txen_restart_pop", 32'(fifoRe_o[0]), 32'd1);
    wait_idle(0, 100);
    txEn[0] = 1'b0;
    repeat (3) @(negedge clk);

    // Async reset during D5 of 0xC6, between clock edges.
    q0.push_back(8'hC6);
    txEn[0] = 1'b1;
    wait_re(0, 20);
    repeat (25) @(negedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("async_rst_tx", 32'(tx_o[0]), 32'd1);
    chk("async_rst_busy", 32'(busy_o[0]), 32'd0);
    chk("async_rst_re", 32'(fifoRe_o[0]), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    s_re   = re_cnt[0];
    s_busy = busy_cnt[0];
    repeat (40) @(negedge clk);
    chk("post_rst_no_pop", 32'(re_cnt[0] - s_re), 32'd0);
    chk("post_rst_idle", 32'(busy_cnt[0] - s_busy), 32'd0);
    txEn[0] = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo_drain.md
Name: uart_tx_fifo_drain

Overview:
- UART transmit serializer that sits directly downstream of the 8-bit byte FIFO.
- Whenever the FIFO is non-empty and transmission is enabled, it pops one byte and shifts it out as an 8N1 or 8E1 frame on a serial line.
- It drives the FIFO read strobe and consumes the FIFO's head-of-queue data and empty flag.

Parameters:
- CLKS_PER_BIT, 434, clk cycles per serial bit (50 MHz / 115200); legal range 2..65535.
- PARITY_EN, 0, 0 = no parity bit; 1 = even parity bit inserted after D7.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- txEn  input  1  high = new frames may start; low = finish current frame, then hold idle.
- fifoData  input  8  FIFO head-of-queue byte, valid while fifoEmpty=0.
- fifoEmpty  input  1  FIFO empty flag.
- fifoRe  output  1  FIFO pop strobe, registered, exactly one cycle per frame.
- tx  output  1  serial line, idle high.
- busy  output  1  high while a frame is in progress (START..STOP).

Behaviour:
- Reset (reset=0, async): state=IDLE, tx=1, fifoRe=0, busy=0, bit counter=0, baud counter=0, shift register=0. Outputs take these values immediately, not at the next edge.
- All outputs are registered. No combinational path exists from inputs to outputs.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - tx=1, busy=0.
  - On an edge with txEn=1 and fifoEmpty=0: shift<=fifoData, fifoRe<=1, tx<=0, busy<=1, baud counter<=0, state<=START.
  - Otherwise remain in IDLE.
- fifoRe is high for exactly the one cycle following the IDLE capture edge, then returns to 0. The FIFO pops on the next edge.
- fifoEmpty and fifoData are sampled only in IDLE. They are ignored in all other states.
- fifoRe is never asserted when fifoEmpty was 1 at the sampling edge.
- Bit timing: every non-IDLE state holds tx for exactly CLKS_PER_BIT cycles. The baud counter is 16 bits, counts 0..CLKS_PER_BIT-1, then advances the state.
- START: tx=0 for one bit time, then DATA.
- DATA:
  - Sends 8 bits, LSB first; tx = shift[0]; shift right at each bit boundary.
  - A 3-bit counter counts 0..7.
  - After bit 7, go to PARITY if PARITY_EN=1, else STOP.
- PARITY: tx = XOR of the 8 data bits (even parity), one bit time.
- STOP: tx=1 for one bit time, then IDLE with busy<=0.
- Back-to-back frames: IDLE lasts a minimum of one cycle. The effective stop period is therefore CLKS_PER_BIT+1 cycles when the FIFO stays non-empty.
- Frame period is 10*CLKS_PER_BIT+1 cycles (11*CLKS_PER_BIT+1 with parity).
- txEn deassertion mid-frame: the current frame completes unchanged. No further pop occurs until txEn=1.
- FIFO becoming empty mid-frame: no effect. The block idles after STOP.
- Reset mid-frame: the frame is aborted and tx returns to 1 immediately. The popped byte is discarded and not retransmitted.
- FIFO writes during transmission are the FIFO's concern. This block never reads fifoData outside IDLE.

Test Plan:
- Reset: hold reset=0 with fifoEmpty=0, txEn=1 -> tx=1, fifoRe=0, busy=0 throughout; no pop.
- Single byte, CLKS_PER_BIT=4, PARITY_EN=0, FIFO holds 0x55:
  - fifoRe is one 1-cycle pulse.
  - tx = 0,1,0,1,0,1,0,1,0,1, each held 4 cycles (40 cycles).
  - busy is high for exactly those 40 cycles.
- Parity, PARITY_EN=1, byte 0x07 -> tx = 0, 1,1,1,0,0,0,0,0, parity 1, stop 1; 44 cycles.
- Back-to-back, FIFO holds 0xA3 then 0x0F -> two fifoRe pulses 41 cycles apart; second start bit follows stop with one idle-high cycle; decoded bytes are 0xA3, 0x0F.
- txEn toggle: drop txEn during bit D3 of 0x81 -> frame completes; no further fifoRe while txEn=0 with FIFO non-empty; raise txEn -> next frame starts after one IDLE cycle.
- Async reset mid-frame: assert reset=0 during bit D5 between clock edges -> tx=1 and busy=0 before the next edge; after release with FIFO empty, the line stays idle.
